alu_issue_ctrl: RTL and testbench

- Command-side driver for the 8-bit ALU (Ain/Bin/Carryin/op/alu_enabled in; alu_out/Carryout out). It owns the other end of that interface.
- Accepts ALU commands over a valid/ready handshake and reads operands from a small internal register file.
- Drives the ALU inputs for ALU_LAT cycles, captures alu_out/Carryout into the destination register and a carry flag, then returns the result over a valid/ready response channel.

---
 rtl/alu_issue_ctrl.sv | 172 +++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Command-side controller for the 8-bit ALU: accepts commands, reads operands from a small
// register file, drives the ALU for ALU_LAT cycles, writes back and returns the result.
module alu_issue_ctrl #(
  parameter int NREG    = 4,
  parameter int ALU_LAT = 1,
  localparam int IW     = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_load,
  input  logic [2:0]    cmd_op,
  input  logic [IW-1:0] cmd_dst,
  input  logic [IW-1:0] cmd_srca,
  input  logic [IW-1:0] cmd_srcb,
  input  logic          cmd_imm_en,
  input  logic [7:0]    cmd_imm,
  input  logic          cmd_cin_sel,
  output logic [7:0]    Ain,
  output logic [7:0]    Bin,
  output logic          Carryin,
  output logic [2:0]    op,
  output logic          alu_enabled,
  input  logic [7:0]    alu_out,
  input  logic          Carryout,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [7:0]    rsp_data,
  output logic          rsp_carry,
  input  logic [IW-1:0] dbg_sel,
  output logic [7:0]    dbg_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [1:0] LAT_LAST = 2'(ALU_LAT - 1);

  state_t          state_reg, state_next;
  logic [7:0]      ain_reg, ain_next;
  logic [7:0]      bin_reg, bin_next;
  logic [2:0]      op_reg, op_next;
  logic            cin_reg, cin_next;
  logic [IW-1:0]   dst_reg, dst_next;
  logic [1:0]      lat_reg, lat_next;
  logic            carry_reg, carry_next;
  logic [7:0]      rsp_data_reg, rsp_data_next;
  logic            rsp_carry_reg, rsp_carry_next;

  logic            wr_en;
  logic [IW-1:0]   wr_idx;
  logic [7:0]      wr_data;
  logic [NREG*8-1:0] regs_flat;

  function automatic logic [7:0] rd_reg(input logic [IW-1:0] idx);
    return regs_flat[int'(idx)*8 +: 8];
  endfunction

  // One register per generate slice; flattened so the read mux can use a variable index.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    logic [7:0] q_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q_reg <= 8'd0;
      end else if (wr_en && (wr_idx == IW'(gi))) begin
        q_reg <= wr_data;
      end
    end
    assign regs_flat[gi*8 +: 8] = q_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ain_reg       <= 8'd0;
      bin_reg       <= 8'd0;
      op_reg        <= 3'd0;
      cin_reg       <= 1'b0;
      dst_reg       <= '0;
      lat_reg       <= 2'd0;
      carry_reg     <= 1'b0;
      rsp_data_reg  <= 8'd0;
      rsp_carry_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ain_reg       <= ain_next;
      bin_reg       <= bin_next;
      op_reg        <= op_next;
      cin_reg       <= cin_next;
      dst_reg       <= dst_next;
      lat_reg       <= lat_next;
      carry_reg     <= carry_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_carry_reg <= rsp_carry_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ain_next       = ain_reg;
    bin_next       = bin_reg;
    op_next        = op_reg;
    cin_next       = cin_reg;
    dst_next       = dst_reg;
    lat_next       = lat_reg;
    carry_next     = carry_reg;
    rsp_data_next  = rsp_data_reg;
    rsp_carry_next = rsp_carry_reg;
    wr_en          = 1'b0;
    wr_idx         = dst_reg;
    wr_data        = alu_out;

    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_load) begin
            wr_en          = 1'b1;
            wr_idx         = cmd_dst;
            wr_data        = cmd_imm;
            rsp_data_next  = cmd_imm;
            rsp_carry_next = carry_reg;
            state_next     = RESP;
          end else begin
            // Operands are snapshotted here, so the later write to dst cannot disturb them.
            ain_next   = rd_reg(cmd_srca);
            bin_next   = cmd_imm_en ? cmd_imm : rd_reg(cmd_srcb);
            op_next    = cmd_op;
            cin_next   = cmd_cin_sel & carry_reg;
            dst_next   = cmd_dst;
            lat_next   = 2'd0;
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (lat_reg == LAT_LAST) begin
          wr_en          = 1'b1;
          carry_next     = Carryout;
          rsp_data_next  = alu_out;
          rsp_carry_next = Carryout;
          ain_next       = 8'd0;
          bin_next       = 8'd0;
          op_next        = 3'd0;
          cin_next       = 1'b0;
          lat_next       = 2'd0;
          state_next     = RESP;
        end else begin
          lat_next = lat_reg + 2'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ALU operand registers are only non-zero while in ISSUE.
  assign Ain         = ain_reg;
  assign Bin         = bin_reg;
  assign op          = op_reg;
  assign Carryin     = cin_reg;
  assign alu_enabled = (state_reg == ISSUE);
  assign cmd_ready   = (state_reg == IDLE);
  assign rsp_valid   = (state_reg == RESP);
  assign rsp_data    = rsp_data_reg;
  assign rsp_carry   = rsp_carry_reg;
  assign dbg_data    = rd_reg(dbg_sel);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: two instances (ALU_LAT=1 and 3) with adder ALU stubs, checked against a register-file model.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_load = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic [1:0] cmd_dst = 2'd0, cmd_srca = 2'd0, cmd_srcb = 2'd0;
  logic       cmd_imm_en = 1'b0;
  logic [7:0] cmd_imm = 8'd0;
  logic       cmd_cin_sel = 1'b0;
  logic       rsp_ready = 1'b0;
  logic [1:0] dbg_sel = 2'd0;
  logic       sel3 = 1'b0;

  logic       cv_w      [2];
  logic       ready_w   [2];
  logic [7:0] ain_w     [2];
  logic [7:0] bin_w     [2];
  logic       cin_w     [2];
  logic [2:0] op_w      [2];
  logic       en_w      [2];
  logic [7:0] aout_w    [2];
  logic       cout_w    [2];
  logic       rv_w      [2];
  logic [7:0] rdata_w   [2];
  logic       rcarry_w  [2];
  logic [7:0] dbg_w     [2];

  int checks = 0;
  int errors = 0;
  logic [7:0] mregs [2][4];
  logic       mcarry [2];
  logic [7:0] last_data;
  logic       last_carry;

  always #5 clk = ~clk;

  assign cv_w[0] = cmd_valid & ~sel3;
  assign cv_w[1] = cmd_valid & sel3;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    assign {cout_w[gi], aout_w[gi]} = 9'(ain_w[gi]) + 9'(bin_w[gi]) + 9'(cin_w[gi]);
    alu_issue_ctrl #(.NREG(4), .ALU_LAT(gi == 0 ? 1 : 3)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cv_w[gi]), .cmd_ready(ready_w[gi]),
      .cmd_load(cmd_load), .cmd_op(cmd_op), .cmd_dst(cmd_dst),
      .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb), .cmd_imm_en(cmd_imm_en),
      .cmd_imm(cmd_imm), .cmd_cin_sel(cmd_cin_sel),
      .Ain(ain_w[gi]), .Bin(bin_w[gi]), .Carryin(cin_w[gi]), .op(op_w[gi]),
      .alu_enabled(en_w[gi]), .alu_out(aout_w[gi]), .Carryout(cout_w[gi]),
      .rsp_valid(rv_w[gi]), .rsp_ready(rsp_ready), .rsp_data(rdata_w[gi]),
      .rsp_carry(rcarry_w[gi]), .dbg_sel(dbg_sel), .dbg_data(dbg_w[gi])
    );
  end

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, sel3 ? 3 : 1, obs, exp);
    end
  endtask

  task automatic chk_alu_idle(input string tag);
    int s = int'(sel3);
    chk({tag, "_en"}, 9'(en_w[s]), 9'd0);
    chk({tag, "_ain"}, 9'(ain_w[s]), 9'd0);
    chk({tag, "_bin"}, 9'(bin_w[s]), 9'd0);
    chk({tag, "_cin"}, 9'(cin_w[s]), 9'd0);
    chk({tag, "_op"}, 9'(op_w[s]), 9'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    for (int s = 0; s < 2; s++) begin
      mcarry[s] = 1'b0;
      for (int r = 0; r < 4; r++) mregs[s][r] = 8'd0;
    end
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel3 = s[0];
      for (int r = 0; r < 4; r++) begin
        dbg_sel = 2'(r);
        #1 chk("rst_dbg", 9'(dbg_w[s]), 9'd0);
      end
      chk_alu_idle("rst");
      chk("rst_rv", 9'(rv_w[s]), 9'd0);
      chk("rst_rdata", 9'(rdata_w[s]), 9'd0);
      chk("rst_rcarry", 9'(rcarry_w[s]), 9'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel3 = s[0];
      #1 chk("rst_ready", 9'(ready_w[s]), 9'd1);
    end
  endtask

  // One full command on the selected instance: accept, ISSUE cycles, RESP held 'hold' cycles, handshake.
  task automatic do_cmd(input bit sel, input bit ld, input logic [2:0] o, input logic [1:0] d,
                        input logic [1:0] a, input logic [1:0] b, input bit ie,
                        input logic [7:0] im, input bit cs, input int hold);
    int s = int'(sel);
    int lat = sel ? 3 : 1;
    logic [7:0] ea, eb, ed;
    logic       ec, ecar;
    logic [8:0] sum;
    @(negedge clk);
    sel3 = sel;
    dbg_sel = d;
    #1 chk("pre_ready", 9'(ready_w[s]), 9'd1);
    ea = mregs[s][a];
    eb = ie ? im : mregs[s][b];
    ec = cs ? mcarry[s] : 1'b0;
    cmd_load = ld; cmd_op = o; cmd_dst = d; cmd_srca = a; cmd_srcb = b;
    cmd_imm_en = ie; cmd_imm = im; cmd_cin_sel = cs; cmd_valid = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cmd_imm = ~im;
    if (ld) begin
      ed = im; ecar = mcarry[s];
    end else begin
      sum = 9'(ea) + 9'(eb) + 9'(ec);
      ed = sum[7:0]; ecar = sum[8];
      mcarry[s] = ecar;
      for (int k = 0; k < lat; k++) begin
        @(negedge clk);
        chk("iss_en", 9'(en_w[s]), 9'd1);
        chk("iss_ain", 9'(ain_w[s]), 9'(ea));
        chk("iss_bin", 9'(bin_w[s]), 9'(eb));
        chk("iss_cin", 9'(cin_w[s]), 9'(ec));
        chk("iss_op", 9'(op_w[s]), 9'(o));
        chk("iss_rv", 9'(rv_w[s]), 9'd0);
        chk("iss_ready", 9'(ready_w[s]), 9'd0);
      end
    end
    mregs[s][d] = ed;
    @(negedge clk);
    chk("rsp_valid", 9'(rv_w[s]), 9'd1);
    chk("rsp_data", 9'(rdata_w[s]), 9'(ed));
    chk("rsp_carry", 9'(rcarry_w[s]), 9'(ecar));
    chk("rsp_ready_lo", 9'(ready_w[s]), 9'd0);
    chk("rsp_dbg", 9'(dbg_w[s]), 9'(ed));
    chk_alu_idle("rsp");
    last_data = rdata_w[s];
    last_carry = rcarry_w[s];
    for (int h = 0; h < hold; h++) begin
      // A competing load offered while the response is stalled must not be taken.
      cmd_load = 1'b1; cmd_imm = ~ed; cmd_valid = 1'b1;
      @(negedge clk);
      chk("hold_valid", 9'(rv_w[s]), 9'd1);
      chk("hold_data", 9'(rdata_w[s]), 9'(ed));
      chk("hold_carry", 9'(rcarry_w[s]), 9'(ecar));
      chk("hold_ready", 9'(ready_w[s]), 9'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("done_rv", 9'(rv_w[s]), 9'd0);
    chk("done_ready", 9'(ready_w[s]), 9'd1);
    chk("done_dbg", 9'(dbg_w[s]), 9'(mregs[s][d]));
    rsp_ready = 1'b0;
  endtask

  initial begin
    do_reset();

    do_cmd(1'b0, 1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'd130, 1'b0, 0);
    do_cmd(1'b0, 1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 1'b0, 8'd25, 1'b0, 0);
    dbg_sel = 2'd0;
    #1 chk("dbg_r0_130", 9'(dbg_w[0]), 9'd130);

    do_cmd(1'b0, 1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'd167, 1'b0, 0);
    do_cmd(1'b0, 1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 1'b0, 8'd117, 1'b0, 0);
    do_cmd(1'b0, 1'b0, 3'd1, 2'd2, 2'd0, 2'd1, 1'b0, 8'd0, 1'b0, 0);
    chk("add_data_28", 9'(last_data), 9'd28);
    chk("add_carry_1", 9'(last_carry), 9'd1);
    do_cmd(1'b0, 1'b0, 3'd1, 2'd2, 2'd2, 2'd0, 1'b1, 8'd98, 1'b1, 5);
    chk("imm_data_127", 9'(last_data), 9'd127);
    chk("imm_carry_0", 9'(last_carry), 9'd0);

    do_cmd(1'b1, 1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'd167, 1'b0, 0);
    do_cmd(1'b1, 1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 1'b0, 8'd117, 1'b0, 0);
    do_cmd(1'b1, 1'b0, 3'd1, 2'd2, 2'd0, 2'd1, 1'b0, 8'd0, 1'b0, 0);
    chk("lat3_data_28", 9'(last_data), 9'd28);

    for (int i = 0; i < 40; i++) begin
      do_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 3'($urandom),
             2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 8'($urandom),
             1'($urandom), int'($urandom_range(0, 2)));
    end

    // Reset in the middle of an ISSUE on the ALU_LAT=3 instance.
    do_reset();
    @(negedge clk);
    sel3 = 1'b1; dbg_sel = 2'd2;
    cmd_load = 1'b0; cmd_op = 3'd2; cmd_dst = 2'd2; cmd_srca = 2'd0;
    cmd_imm_en = 1'b1; cmd_imm = 8'd77; cmd_cin_sel = 1'b0; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("abort_en_before", 9'(en_w[1]), 9'd1);
    rst_n = 1'b0;
    #1 chk_alu_idle("abort");
    chk("abort_rv", 9'(rv_w[1]), 9'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_rsp", 9'(rv_w[1]), 9'd0);
      chk("abort_dst", 9'(dbg_w[1]), 9'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
